// File: rtl/fork_router.sv
// fork_router: single-source, multi-destination flit fork.
// The selected input feeds a first-word-fall-through ring buffer. The head flit is
// offered to every masked output. It is popped once all masked outputs have taken it.
`ifndef DW
`define DW 8
`endif

module fork_router #(
  parameter logic [4:0] input_sel        = 5'b10000,
  parameter logic [4:0] output_mask      = 5'b00000,
  parameter int         buffer_depth_log = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [4:0][`DW-1:0]   data_i,
  input  logic [4:0]            valid_i,
  output logic [4:0]            ready_o,
  output logic [4:0][`DW-1:0]   data_o,
  output logic [4:0]            valid_o,
  input  logic [4:0]            ready_i
);

  localparam int AW    = buffer_depth_log;
  localparam int CW    = buffer_depth_log + 1;
  localparam int DEPTH = 1 << buffer_depth_log;

  logic [`DW-1:0] mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [4:0]     done_q, done_d;

  logic [`DW-1:0] in_data, head;
  logic           in_valid, full, empty, wr_en, pop;
  logic [4:0]     hs, served;

  // Pick the one selected input; every other port's data/valid is masked away.
  always_comb begin
    in_data  = '0;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (input_sel[i]) begin
        in_data  = in_data | data_i[i];
        in_valid = in_valid | valid_i[i];
      end
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // rstn gates ready directly so nothing looks acceptable while reset is held.
  assign ready_o = input_sel & {5{rstn & ~full}};
  // No bypass: a full buffer refuses the write even when it pops this cycle.
  assign wr_en   = in_valid & ~full;

  // valid_o is built only from registered state, never from ready_i.
  assign valid_o = output_mask & ~done_q & {5{~empty}};
  assign hs      = valid_o & ready_i;
  assign served  = done_q | hs;
  // With an empty mask, the reduction is trivially true, so the head drains one per cycle.
  assign pop     = ~empty & (&(served | ~output_mask));

  // Unmasked outputs are tied to zero; masked outputs show the head flit.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      data_o[i] = output_mask[i] ? head : '0;
    end
  end

  // Next-state for pointers, occupancy and the per-output "already taken" flags.
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    done_d = pop ? 5'b00000 : (done_q | hs);
  end

  // Control state: async reset drops all buffered flits and partial delivery state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  // Flit storage, deliberately unreset: contents only matter once written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: doc/fork_router.md
FORK_ROUTER -- requirements
Module: fork_router

Interface
REQ-001 SHALL have parameter input_sel, [0:4], default 5'b10000: one-hot source port ([0]-local [1]-west [2]-east [3]-north [4]-south).
REQ-002 SHALL have parameter output_mask, [0:4], default 0: destination ports, 1 = copy flit to that port, same bit order.
REQ-003 SHALL have parameter buffer_depth_log, default 2: input buffer holds 2**buffer_depth_log flits.
REQ-004 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-005 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port data_i[5], input, `DW each: flit from each port, `DW from params.svh.
REQ-007 SHALL have port valid_i[5], input, 1 each: flit valid per input port.
REQ-008 SHALL have port ready_o[5], output, 1 each: buffer can accept, per input port.
REQ-009 SHALL have port data_o[5], output, `DW each: flit to each port.
REQ-010 SHALL have port valid_o[5], output, 1 each: flit valid per output port.
REQ-011 SHALL have port ready_i[5], input, 1 each: downstream accepts, per output port.

Function
REQ-012 SHALL take flits only from the port selected by input_sel; ready_o[i] SHALL be 0 for every unselected i, and their data_i/valid_i SHALL be ignored.
REQ-013 SHALL hold a first-word-fall-through circular buffer with registered count, rd_ptr and wr_ptr; full = (count == depth), empty = (count == 0).
REQ-014 SHALL drive ready_o[sel] = ~full and write when valid_i[sel] & ready_o[sel].
REQ-015 SHALL NOT write in a full cycle, even if the same cycle pops (no bypass); pointers SHALL wrap modulo depth.
REQ-016 SHALL pass flits bit-exact with no change to header bits or payload.
REQ-017 SHALL show a flit written in cycle N on the outputs from cycle N+1; minimum latency is 1 cycle.
REQ-018 SHALL keep a registered done[0:4] vector, one bit per output, meaning "head flit already taken by this output".
REQ-019 SHALL drive valid_o[i] = output_mask[i] & ~empty & ~done[i], and data_o[i] = head flit when output_mask[i] is set.
REQ-020 SHALL drive data_o[i] = 0 and valid_o[i] = 0 for every unmasked i.
REQ-021 SHALL treat port i as served this cycle if done[i] | (valid_o[i] & ready_i[i]).
REQ-022 SHALL pop the head when ~empty and every masked port is served; done SHALL then clear to 0 on the same edge.
REQ-023 SHALL otherwise set done[i] on each handshake valid_o[i] & ready_i[i] and hold it; each output therefore sees each flit exactly once.
REQ-024 SHALL, with simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-025 SHALL, when output_mask == 0, discard the head by popping once per cycle while ~empty.
REQ-026 SHALL NOT let valid_o[i] depend combinationally on ready_i[i]; it depends only on registered state.
REQ-027 SHALL hold data_o stable while valid_o[i] is high and no handshake has happened on port i.

Reset
REQ-028 SHALL, while rstn = 0 (asynchronous), clear count, rd_ptr, wr_ptr and done to 0.
REQ-029 SHALL, during reset, drive all valid_o = 0 and all ready_o = 0.
REQ-030 SHALL, after rstn rises, assert ready_o[sel] = 1 in the first cycle.
REQ-031 SHALL keep buffer storage unreset; its contents are don't-care until written.
REQ-032 SHALL, on reset asserted mid-transfer, drop every buffered flit and clear partial done state; nothing is replayed after reset.

Verification
REQ-033 Basic fork: input_sel = west, output_mask = local|east, all ready_i = 1; push 0x1, 0x2, 0x3 back-to-back -> both outputs carry 1, 2, 3 on consecutive cycles starting 1 cycle after each push; no duplicates.
REQ-034 Skewed ready: mask = east|north, east ready, north stalled 3 cycles -> east takes flit A once and valid_o[east] drops; north takes A on release; pop happens in that same cycle; B follows the next cycle.
REQ-035 Full: depth 4, all ready_i = 0, push 6 -> ready_o[sel] falls after the 4th accept; with full plus a same-cycle pop, the write is refused; order is kept after release.
REQ-036 Wrap: 20 flits of random data with random ready_i -> per-output streams equal the input stream exactly; count never exceeds 4.
REQ-037 Reset mid-operation: 3 flits buffered, done partially set, pulse rstn low asynchronously -> valid_o = 0 at once; after reset no stale flit appears, and a new flit 0xAA arrives on all masked outputs.
REQ-038 Unselected and unmasked ports: drive valid_i on an unselected port -> ready_o = 0 on it, and unmasked outputs stay valid_o = 0 and data_o = 0 throughout.
